mac_tile_sequencer: RTL and testbench
=====================================

# mac_tile_sequencer

Control sequencer for an N×N systolic tile of `mac_unit` processing elements. It accepts one tile job (accumulation depth `k_len`) and loads bias into every PE. It then issues skewed per-PE accumulate enables as operand beats are accepted, waits for the skew pipeline to drain, and streams the N×N int32 results out one row per beat. It sits between the tile scheduler (job and operand streams) and the PE array and output buffer.

## Interface
- `N`, 4: array dimension; PE (r,c) maps to flat index r*N+c.
- `K_W`, 16: width of `k_len`.

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start_valid`  in  1  job request.
- `start_ready`  out  1  high only in IDLE.
- `k_len`  in  K_W  accumulation depth; sampled on the start handshake.
- `feed_valid`  in  1  operand beat present at the array edge this cycle.
- `feed_ready`  out  1  high only in FEED while beats remain.
- `mac_load_bias`  out  1  broadcast to all PE `load_bias`.
- `mac_enable`  out  N*N  per-PE `enable`, bit r*N+c.
- `sum_in`  in  N*N*32  PE `sum_out` values, signed, PE r*N+c at bits [32(r*N+c)+31 : 32(r*N+c)].
- `out_valid`  out  1  result row valid.
- `out_ready`  in  1  consumer accepts the row.
- `out_row`  out  N*32  row r of `sum_in`, lane c at bits [32c+31:32c].
- `out_row_idx`  out  $clog2(N)  current row.
- `out_last`  out  1  high with row N-1.
- `busy`  out  1  high when state ≠ IDLE.

## Operation
- States: IDLE → BIAS → FEED → DRAIN → OUT → IDLE.
- **IDLE:** `start_ready`=1. When `start_valid` is high, latch `k_len`, clear the beat counter and go to BIAS.
- **BIAS:** exactly one cycle, `mac_load_bias`=1 and `mac_enable`=0. Go to FEED, or to DRAIN if the latched `k_len`=0.
- **FEED:**
  - `feed_ready`=1 while beats accepted < `k_len`.
  - Accept = `feed_valid` & `feed_ready`. It increments the counter and enters the skew shift register.
  - Exit to DRAIN in the cycle after the final beat is accepted.
  - `feed_valid` low inserts a bubble: no enable is generated for that slot, and the bubble propagates diagonally.
- **Skew:**
  - Shift register of depth 2N-2 carries accept history.
  - `mac_enable[r*N+c]` = accept delayed by r+c cycles.
  - Delay 0 is the combinational accept, so PE(0,0) enables in the same cycle its beat arrives.
  - The register shifts every cycle in FEED and DRAIN and is cleared in IDLE and BIAS.
- **DRAIN:** `feed_ready`=0. Stay until the skew register is all zero, with a minimum of one cycle. Then go to OUT with row index 0.
- **OUT:**
  - `out_valid`=1, `out_row` = row `out_row_idx` of `sum_in`.
  - On handshake, the index increments.
  - A handshake on row N-1 (`out_last`) returns to IDLE.
  - PE accumulators hold because `mac_enable`=0, so `sum_in` is stable through OUT.
- **Width and overflow:** `k_len` is unsigned. Counter wrap is impossible because the counter has the same width as `k_len` and stops at `k_len`. No arithmetic is performed on sums except the optional ReLU.
- **Gating:**
  - `mac_load_bias` and `mac_enable` are never high in the same cycle.
  - `out_row` is 0 when `out_valid`=0.
- **Reset mid-operation:** immediate return to IDLE. All outputs drop to reset values and in-flight results are discarded. The PE array must be reset or bias-reloaded by the next job, which BIAS guarantees.

## Timing
- Reset values:
  - `start_ready`=1 (IDLE).
  - `busy`, `feed_ready`, `mac_load_bias`, `mac_enable`, `out_valid`, `out_last`, `out_row`, `out_row_idx` all 0.
- The start handshake at edge E0 puts BIAS in the cycle after E0, and FEED begins one cycle later.
- With no stalls, FEED lasts `k_len` cycles and DRAIN lasts 2N-2 cycles (1 if N=1 or `k_len`=0).
- The first `out_valid` comes 1 + `k_len` + 2N-2 cycles after the first BIAS cycle, with no stalls.
- OUT lasts at least N cycles; `out_ready` low holds the row and index stable.
- `start_ready` returns the cycle after the `out_last` handshake; back-to-back jobs have no extra idle cycle.

## Configuration
- `MAC_SEQ_RELU_EN`:
  - Defined: each `out_row` lane with a negative `sum_in` value (bit 31 set) is driven as 0. Non-negative values pass unchanged.
  - Undefined: lanes pass `sum_in` unmodified. Control timing is identical either way.

## Test plan
- **Reset:** `reset` pulse mid-FEED, asynchronous and not clock-aligned → all outputs 0 before the next edge and `start_ready`=1. A new job then completes normally.
- **Basic job:** N=4, `k_len`=3, `feed_valid` held high → one `mac_load_bias` cycle, 3 FEED cycles, `mac_enable[15]` first high 6 cycles after the first accept, `out_valid` at cycle 10 after BIAS, and rows 0..3 with `out_last` on row 3.
- **Feed stall:** `k_len`=4 with `feed_valid` low on the second slot → enable pattern shows a diagonal bubble, each PE receives exactly 4 enables, and `feed_ready` stays high until the 4th accept.
- **Zero depth:** `k_len`=0 → BIAS, then 1 DRAIN cycle, then OUT. No `mac_enable` bit is ever high and the rows equal the loaded bias.
- **Output backpressure:** `out_ready` low for 5 cycles on row 1 → `out_row` and `out_row_idx`=1 stable throughout. Exactly N handshakes occur, then IDLE.
- **ReLU:** with `MAC_SEQ_RELU_EN` defined, `sum_in` lane = -7 (0xFFFFFFF9) → `out_row` lane 0. Without the macro → 0xFFFFFFF9.

Source files
------------

// File: rtl/mac_tile_sequencer.sv
// mac_tile_sequencer: runs one NxN MAC tile job -- bias load, skewed accumulate enables, drain, row-by-row readout.
// Latency: first out_valid 1 + k_len + 2N-2 cycles after the BIAS cycle when feed_valid never stalls.
// Backpressure: feed_valid low inserts a diagonal enable bubble; out_ready low holds out_row/out_row_idx.
// Optional build macro MAC_SEQ_RELU_EN: negative result lanes are driven as zero on out_row.
module mac_tile_sequencer #(
    parameter int N   = 4,
    parameter int K_W = 16,
    localparam int RW = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [K_W-1:0]     k_len,
    input  logic               feed_valid,
    output logic               feed_ready,
    output logic               mac_load_bias,
    output logic [N*N-1:0]     mac_enable,
    input  logic [N*N*32-1:0]  sum_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N*32-1:0]    out_row,
    output logic [RW-1:0]      out_row_idx,
    output logic               out_last,
    output logic               busy
);

    // Skew history depth: PE(r,c) needs the accept from r+c cycles ago, delay 0 is combinational.
    localparam int SK = (N > 1) ? 2 * N - 2 : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BIAS  = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [K_W-1:0] k_q;
    logic [K_W-1:0] cnt_q;
    logic [SK-1:0]  skew_q;
    logic [SK-1:0]  skew_shift;
    logic [RW-1:0]  row_q;
    logic           accept;
    logic           last_row;
    logic [31:0]    lane;

    assign accept   = feed_valid && feed_ready;
    assign last_row = (row_q == RW'(N - 1));

    // Operand beats are taken only while the job still owes beats.
    always_comb begin
        feed_ready = 1'b0;
        if (state == S_FEED && cnt_q < k_q) begin
            feed_ready = 1'b1;
        end
    end

    // Next value of the accept history: new accept enters at delay 1, older ones age by one.
    always_comb begin
        skew_shift    = '0;
        skew_shift[0] = (N > 1) ? accept : 1'b0;
        for (int i = 1; i < SK; i++) begin
            skew_shift[i] = skew_q[i-1];
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control outputs.
    always_comb begin
        state_nxt     = state;
        start_ready   = 1'b0;
        busy          = 1'b1;
        mac_load_bias = 1'b0;
        out_valid     = 1'b0;
        case (state)
            S_IDLE: begin
                start_ready = 1'b1;
                busy        = 1'b0;
                if (start_valid) begin
                    state_nxt = S_BIAS;
                end
            end
            S_BIAS: begin
                mac_load_bias = 1'b1;
                state_nxt     = (k_q == '0) ? S_DRAIN : S_FEED;
            end
            S_FEED: begin
                if (accept && (cnt_q + K_W'(1)) == k_q) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Leave once the last in-flight enable has reached the far corner PE.
                if (skew_shift == '0) begin
                    state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready && last_row) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Job depth latch and accepted-beat counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k_q   <= '0;
            cnt_q <= '0;
        end else if (state == S_IDLE && start_valid) begin
            k_q   <= k_len;
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= cnt_q + K_W'(1);
        end
    end

    // Accept history shifts while operands are flowing through the array, otherwise held clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skew_q <= '0;
        end else if (state == S_FEED || state == S_DRAIN) begin
            skew_q <= skew_shift;
        end else begin
            skew_q <= '0;
        end
    end

    // Output row index: zero on entry to OUT, advances per accepted row.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_q <= '0;
        end else if (state != S_OUT) begin
            row_q <= '0;
        end else if (out_ready) begin
            row_q <= last_row ? '0 : row_q + RW'(1);
        end
    end

    // Diagonal enable wavefront: PE(r,c) sees the accept from r+c cycles earlier.
    always_comb begin
        mac_enable = '0;
        if (state == S_FEED || state == S_DRAIN) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    if (r + c == 0) begin
                        mac_enable[r*N+c] = accept;
                    end else begin
                        mac_enable[r*N+c] = skew_q[r+c-1];
                    end
                end
            end
        end
    end

    // Result row mux, forced to zero outside OUT.
    always_comb begin
        out_row = '0;
        lane    = '0;
        if (out_valid) begin
            for (int c = 0; c < N; c++) begin
                lane = sum_in[32*(int'(row_q)*N + c) +: 32];
`ifdef MAC_SEQ_RELU_EN
                if (lane[31]) begin
                    lane = '0;
                end
`else
`endif
                out_row[32*c +: 32] = lane;
            end
        end
    end

    assign out_row_idx = row_q;
    assign out_last    = out_valid && last_row;

endmodule

// File: tb/tb_mac_tile_sequencer.sv
// tb_mac_tile_sequencer: drives tile jobs into mac_tile_sequencer with a behavioural PE array model.
// Latency: expectations derived from job depth and accept times, checked every cycle.
// Backpressure: exercises feed bubbles and out_ready stalls, random and targeted.
module tb_mac_tile_sequencer;

    localparam int N   = 4;
    localparam int K_W = 16;
    localparam int RW  = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start_valid = 1'b0;
    logic              start_ready;
    logic [K_W-1:0]    k_len = '0;
    logic              feed_valid = 1'b0;
    logic              feed_ready;
    logic              mac_load_bias;
    logic [N*N-1:0]    mac_enable;
    logic [N*N*32-1:0] sum_in;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [N*32-1:0]   out_row;
    logic [RW-1:0]     out_row_idx;
    logic              out_last;
    logic              busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] bias_v [N*N];
    logic [31:0] inc_v  [N*N];
    logic [31:0] pe_acc [N*N];

    mac_tile_sequencer #(.N(N), .K_W(K_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .k_len        (k_len),
        .feed_valid   (feed_valid),
        .feed_ready   (feed_ready),
        .mac_load_bias(mac_load_bias),
        .mac_enable   (mac_enable),
        .sum_in       (sum_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_row      (out_row),
        .out_row_idx  (out_row_idx),
        .out_last     (out_last),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // PE array model: bias load overwrites, each enable adds this PE's fixed increment.
    always @(posedge clk) begin
        for (int p = 0; p < N*N; p++) begin
            if (mac_load_bias) pe_acc[p] <= bias_v[p];
            else if (mac_enable[p]) pe_acc[p] <= pe_acc[p] + inc_v[p];
        end
    end

    always_comb begin
        sum_in = '0;
        for (int p = 0; p < N*N; p++) sum_in[32*p +: 32] = pe_acc[p];
    end

    task automatic set_operands(input bit negative_mix);
        for (int p = 0; p < N*N; p++) begin
            bias_v[p] = $urandom;
            inc_v[p]  = $urandom_range(0, 1000);
            if (negative_mix && (p % 2 == 0)) bias_v[p] = 32'hFFFF_FFF9;
        end
    endtask

    // One full job; every cycle is compared against expectations built from the accept times.
    task automatic run_job(input int k, input int stall_mode, input int bp_row, input int bp_len,
                           input bit rnd_ready, output int ov_cycle);
        bit             hist [0:4095];
        int             acc_n, rows_done, bp_used, out_start, p;
        int             en_cnt [N*N];
        bit             fv, fr_exp, acc, done, exp_ov, en_ok;
        logic [N*N-1:0] exp_en;
        logic [N*32-1:0] exp_row;
        logic [31:0]    val;
        ov_cycle = -1;
        for (int i = 0; i < 4096; i++) hist[i] = 1'b0;
        for (int i = 0; i < N*N; i++) en_cnt[i] = 0;

        @(negedge clk);
        start_valid = 1'b1; k_len = K_W'(k); feed_valid = 1'b0; out_ready = 1'b0;
        #1;
        checks++;
        if (start_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL start_idle: start_ready=%b busy=%b, required 1 0", start_ready, busy);
        end

        @(negedge clk);
        start_valid = 1'b0;
        #1;
        checks++;
        if (mac_load_bias !== 1'b1 || mac_enable !== '0 || feed_ready !== 1'b0 ||
            start_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bias_cycle: load_bias=%b enable=%h feed_ready=%b start_ready=%b busy=%b out_valid=%b, required 1 0000 0 0 1 0",
                     mac_load_bias, mac_enable, feed_ready, start_ready, busy, out_valid);
        end

        acc_n = 0; rows_done = 0; bp_used = 0; done = 1'b0;
        out_start = (k == 0) ? 2 : -1;
        for (int t = 1; t < 2000 && !done; t++) begin
            @(negedge clk);
            fr_exp = (acc_n < k);
            if (stall_mode == 1) fv = (t != 2);
            else if (stall_mode == 2) fv = ($urandom_range(0, 2) != 0);
            else fv = 1'b1;
            if (!fr_exp) fv = $urandom_range(0, 1);
            feed_valid = fv;
            exp_ov = (out_start >= 0) && (t >= out_start);
            if (exp_ov && rows_done == bp_row && bp_used < bp_len) begin
                out_ready = 1'b0;
                bp_used++;
            end else if (rnd_ready || !exp_ov) begin
                out_ready = $urandom_range(0, 1);
            end else begin
                out_ready = 1'b1;
            end
            #1;
            acc = fv && fr_exp;
            hist[t] = acc;
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    exp_en[r*N+c] = (t - (r + c) >= 1) ? hist[t-(r+c)] : 1'b0;

            checks++;
            if (feed_ready !== fr_exp) begin
                errors++;
                $display("FAIL feed_ready t=%0d: got %b, required %b", t, feed_ready, fr_exp);
            end
            checks++;
            if (mac_enable !== exp_en || mac_load_bias !== 1'b0) begin
                errors++;
                $display("FAIL enable_wave t=%0d: enable=%h load_bias=%b, required %h 0", t, mac_enable, mac_load_bias, exp_en);
            end
            for (int i = 0; i < N*N; i++) en_cnt[i] += int'(mac_enable[i]);
            checks++;
            if (out_valid !== exp_ov || busy !== 1'b1 || start_ready !== 1'b0) begin
                errors++;
                $display("FAIL out_valid t=%0d: out_valid=%b busy=%b start_ready=%b, required %b 1 0", t, out_valid, busy, start_ready, exp_ov);
            end
            if (exp_ov) begin
                if (ov_cycle < 0) ov_cycle = t;
                for (int c = 0; c < N; c++) begin
                    p = rows_done * N + c;
                    val = bias_v[p] + 32'(k) * inc_v[p];
`ifdef MAC_SEQ_RELU_EN
                    if (val[31]) val = 32'h0;
`endif
                    exp_row[32*c +: 32] = val;
                end
                checks++;
                if (out_row !== exp_row || out_row_idx !== RW'(rows_done) || out_last !== (rows_done == N-1)) begin
                    errors++;
                    $display("FAIL out_row t=%0d: row=%h idx=%0d last=%b, required %h %0d %b",
                             t, out_row, out_row_idx, out_last, exp_row, rows_done, rows_done == N-1);
                end
                if (out_ready) begin
                    rows_done++;
                    if (rows_done == N) done = 1'b1;
                end
            end else begin
                checks++;
                if (out_row !== '0 || out_last !== 1'b0 || out_row_idx !== '0) begin
                    errors++;
                    $display("FAIL out_idle t=%0d: row=%h last=%b idx=%0d, required 0 0 0", t, out_row, out_last, out_row_idx);
                end
            end
            if (acc) begin
                acc_n++;
                if (acc_n == k) out_start = t + 2*N - 1;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL job_timeout: rows=%0d accepted=%0d, required %0d %0d", rows_done, acc_n, N, k);
        end
        en_ok = 1'b1;
        for (int i = 0; i < N*N; i++) if (en_cnt[i] != k) en_ok = 1'b0;
        checks++;
        if (!en_ok) begin
            errors++;
            $display("FAIL enable_count: PE0=%0d PE15=%0d, required %0d each", en_cnt[0], en_cnt[N*N-1], k);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #12;
        checks++;
        if (start_ready !== 1'b1 || busy !== 1'b0 || feed_ready !== 1'b0 || mac_load_bias !== 1'b0 ||
            mac_enable !== '0 || out_valid !== 1'b0 || out_last !== 1'b0 || out_row !== '0 || out_row_idx !== '0) begin
            errors++;
            $display("FAIL reset_state: start_ready=%b busy=%b feed_ready=%b load_bias=%b enable=%h out_valid=%b, required 1 0 0 0 0 0",
                     start_ready, busy, feed_ready, mac_load_bias, mac_enable, out_valid);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic;
        int ov;
        set_operands(1'b0);
        run_job(3, 0, -1, 0, 1'b0, ov);
        checks++;
        if (ov !== 10) begin
            errors++;
            $display("FAIL basic_latency: first out_valid at %0d, required 10", ov);
        end
    endtask

    task automatic test_feed_stall;
        int ov;
        set_operands(1'b0);
        run_job(4, 1, -1, 0, 1'b0, ov);
        checks++;
        if (ov !== 12) begin
            errors++;
            $display("FAIL stall_latency: first out_valid at %0d, required 12", ov);
        end
    endtask

    task automatic test_zero_depth;
        int ov;
        set_operands(1'b0);
        run_job(0, 0, -1, 0, 1'b0, ov);
        checks++;
        if (ov !== 2) begin
            errors++;
            $display("FAIL zero_latency: first out_valid at %0d, required 2", ov);
        end
    endtask

    task automatic test_backpressure;
        int ov;
        set_operands(1'b0);
        run_job(2, 0, 1, 5, 1'b0, ov);
    endtask

    task automatic test_relu;
        int ov;
        set_operands(1'b1);
        run_job(0, 0, -1, 0, 1'b0, ov);
        for (int p = 0; p < N*N; p++) inc_v[p] = 32'h0;
        run_job(2, 0, -1, 0, 1'b0, ov);
    endtask

    task automatic test_back_to_back;
        int ov;
        for (int j = 0; j < 3; j++) begin
            set_operands(1'b0);
            run_job(j + 1, 0, -1, 0, 1'b0, ov);
        end
    endtask

    task automatic test_random;
        int ov;
        for (int j = 0; j < 6; j++) begin
            set_operands(j[0]);
            run_job($urandom_range(0, 10), 2, -1, 0, 1'b1, ov);
        end
    endtask

    task automatic test_reset_midfeed;
        int ov;
        set_operands(1'b0);
        @(negedge clk);
        start_valid = 1'b1; k_len = K_W'(6);
        @(negedge clk);
        start_valid = 1'b0;
        @(negedge clk);
        feed_valid = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        checks++;
        if (start_ready !== 1'b1 || busy !== 1'b0 || feed_ready !== 1'b0 || mac_load_bias !== 1'b0 ||
            mac_enable !== '0 || out_valid !== 1'b0 || out_last !== 1'b0 || out_row !== '0 || out_row_idx !== '0) begin
            errors++;
            $display("FAIL reset_midfeed: start_ready=%b busy=%b feed_ready=%b enable=%h out_valid=%b, required 1 0 0 0 0",
                     start_ready, busy, feed_ready, mac_enable, out_valid);
        end
        #2;
        reset = 1'b0;
        feed_valid = 1'b0;
        set_operands(1'b0);
        run_job(3, 0, -1, 0, 1'b0, ov);
    endtask

    initial begin
        for (int p = 0; p < N*N; p++) begin
            bias_v[p] = '0;
            inc_v[p]  = '0;
        end
        test_reset();
        test_basic();
        test_feed_stall();
        test_zero_depth();
        test_backpressure();
        test_relu();
        test_back_to_back();
        test_random();
        test_reset_midfeed();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
